// File: rtl/ptrs_resp_if.sv
// Pointer-struct request/response bundle between the SRC controller FSM and ptrs_resp.
// Defining PTRS_STALL_CNT_EN adds the stall_cnt signal.
interface ptrs_resp_if #(
   parameter int DATA_ADDR_W = 6,
   parameter int COEF_ADDR_W = 8
);
   logic                   en;
   logic                   ptrs_req;
   logic                   new_in;
   logic                   req_complete;
   logic                   iw_valid;
   logic [DATA_ADDR_W-1:0] rd_ptr;
   logic [COEF_ADDR_W-1:0] coef_base;
   logic                   credit_ovf;
`ifdef PTRS_STALL_CNT_EN
   logic [15:0]            stall_cnt;
`endif

   modport master (
      output en, ptrs_req, new_in,
      input  req_complete, iw_valid, rd_ptr, coef_base, credit_ovf
`ifdef PTRS_STALL_CNT_EN
      , input stall_cnt
`endif
   );

   modport slave (
      input  en, ptrs_req, new_in,
      output req_complete, iw_valid, rd_ptr, coef_base, credit_ovf
`ifdef PTRS_STALL_CNT_EN
      , output stall_cnt
`endif
   );
endinterface

// File: rtl/ptrs_resp.sv
// Pointer-struct responder: L/M phase accumulator plus input-sample credit tracking.
// Optional macro PTRS_STALL_CNT_EN adds a saturating count of invalid responses.
module ptrs_resp #(
   parameter int L           = 3,
   parameter int M           = 2,
   parameter int TAPS        = 16,
   parameter int DATA_ADDR_W = 6,
   parameter int COEF_ADDR_W = 8
) (
   input logic         clk,
   input logic         rst,
   ptrs_resp_if.slave  bus
);
   localparam int PH_W  = (L > 1) ? $clog2(L) : 1;
   localparam int ACC_W = $clog2(L + M) + 1;
   localparam int CR_W  = DATA_ADDR_W + 1;
   localparam logic [CR_W-1:0] CR_MAX = {1'b1, {DATA_ADDR_W{1'b0}}};

   typedef enum logic [1:0] {IDLE, CHECK, STEP, DONE} state_t;

   state_t                 state, state_n;
   logic [PH_W-1:0]        phase, phase_n;
   logic [ACC_W-1:0]       acc, acc_n;
   logic [CR_W-1:0]        need, need_n;
   logic [CR_W-1:0]        credit;
   logic                   primed;
   logic [DATA_ADDR_W-1:0] rd_q, rd_n;
   logic [COEF_ADDR_W-1:0] coef_q, coef_n;
   logic                   valid_q, valid_n;
   logic                   ovf_q;
   logic                   commit;
   logic                   sat;
   logic                   inc;
   logic [CR_W-1:0]        dec;

   always_comb begin
      state_n = state;
      phase_n = phase;
      acc_n   = acc;
      need_n  = need;
      rd_n    = rd_q;
      coef_n  = coef_q;
      valid_n = valid_q;
      commit  = 1'b0;
      if (bus.en) begin
         case (state)
            IDLE:  if (bus.ptrs_req) state_n = CHECK;
            CHECK: begin
               if (primed && (credit >= need)) begin
                  commit  = 1'b1;
                  rd_n    = rd_q + need[DATA_ADDR_W-1:0];
                  coef_n  = COEF_ADDR_W'(phase) * COEF_ADDR_W'(TAPS);
                  valid_n = 1'b1;
                  acc_n   = ACC_W'(phase) + ACC_W'(M);
                  need_n  = '0;
                  state_n = STEP;
               end else begin
                  valid_n = 1'b0;
                  state_n = DONE;
               end
            end
            // Repeated subtraction: one input sample consumed per branch wrap.
            STEP: begin
               if (acc >= ACC_W'(L)) begin
                  acc_n  = acc - ACC_W'(L);
                  need_n = need + 1'b1;
               end else begin
                  phase_n = PH_W'(acc);
                  state_n = DONE;
               end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         phase   <= '0;
         acc     <= '0;
         need    <= '0;
         rd_q    <= '0;
         coef_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state   <= state_n;
         phase   <= phase_n;
         acc     <= acc_n;
         need    <= need_n;
         rd_q    <= rd_n;
         coef_q  <= coef_n;
         valid_q <= valid_n;
      end
   end

   // Credit runs regardless of en; the priming sample is address 0 and earns no credit.
   assign sat = (credit == CR_MAX);
   assign inc = bus.new_in && primed && !sat;
   assign dec = commit ? need : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         credit <= '0;
         primed <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         credit <= credit + CR_W'(inc) - dec;
         if (bus.new_in) primed <= 1'b1;
         if (bus.new_in && primed && sat) ovf_q <= 1'b1;
      end
   end

   assign bus.req_complete = (state == DONE);
   assign bus.iw_valid     = valid_q;
   assign bus.rd_ptr       = rd_q;
   assign bus.coef_base    = coef_q;
   assign bus.credit_ovf   = ovf_q;

`ifdef PTRS_STALL_CNT_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
      end else if (bus.en && (state == DONE) && !valid_q && (stall_q != '1)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign bus.stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_ptrs_resp.sv
// Bench for ptrs_resp: two configurations checked against a transaction-level model.
module tb_ptrs_resp;
   localparam int AL = 3, AM = 2, AT = 16, AW = 6, ACW = 8;
   localparam int BL = 1, BM = 1, BT = 16, BW = 2, BCW = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ptrs_resp_if #(.DATA_ADDR_W(AW), .COEF_ADDR_W(ACW)) ia();
   ptrs_resp_if #(.DATA_ADDR_W(BW), .COEF_ADDR_W(BCW)) ib();

   ptrs_resp #(.L(AL), .M(AM), .TAPS(AT), .DATA_ADDR_W(AW), .COEF_ADDR_W(ACW))
      dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
   ptrs_resp #(.L(BL), .M(BM), .TAPS(BT), .DATA_ADDR_W(BW), .COEF_ADDR_W(BCW))
      dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

   typedef struct {
      int phase; int need; int credit; int rd; int cb; int stall;
      bit primed; bit valid; bit ovf;
   } mstate_t;

   mstate_t ma, mb;
   int n_checks = 0;
   int n_fail   = 0;

   function automatic void m_reset(output mstate_t s);
      s = '{default: 0};
   endfunction

   function automatic void m_new_in(inout mstate_t s, input int w);
      if (!s.primed) s.primed = 1'b1;
      else if (s.credit == (1 << w)) s.ovf = 1'b1;
      else s.credit++;
   endfunction

   // One request: valid when the samples the struct needs are present.
   function automatic void m_req(inout mstate_t s, input int l, input int m, input int taps,
                                 input int w, input int cw, output int lat);
      if (s.primed && s.credit >= s.need) begin
         s.rd     = (s.rd + s.need) % (1 << w);
         s.cb     = (s.phase * taps) % (1 << cw);
         s.credit = s.credit - s.need;
         s.valid  = 1'b1;
         lat      = 3 + (s.phase + m) / l;
         s.need   = (s.phase + m) / l;
         s.phase  = (s.phase + m) % l;
      end else begin
         s.valid = 1'b0;
         lat     = 2;
         if (s.stall < 65535) s.stall++;
      end
   endfunction

   task automatic pulse_new_in(input bit sel);
      @(negedge clk);
      if (sel) ib.new_in = 1'b1; else ia.new_in = 1'b1;
      @(negedge clk);
      ia.new_in = 1'b0;
      ib.new_in = 1'b0;
      if (sel) m_new_in(mb, BW); else m_new_in(ma, AW);
   endtask

   task automatic do_req(input bit sel, input bit pulse, input string name);
      mstate_t s;
      int lat;
      int n;
      bit sat_before;
      bit rc;
      logic [31:0] g;
      s = sel ? mb : ma;
      sat_before = s.primed && (s.credit == (sel ? (1 << BW) : (1 << AW)));
      if (sel) m_req(s, BL, BM, BT, BW, BCW, lat);
      else     m_req(s, AL, AM, AT, AW, ACW, lat);
      if (pulse) begin
         if (sat_before) s.ovf = 1'b1;
         else m_new_in(s, sel ? BW : AW);
      end
      @(negedge clk);
      if (sel) ib.ptrs_req = 1'b1; else ia.ptrs_req = 1'b1;
      rc = 1'b0;
      for (n = 1; n <= 40; n++) begin
         if (sel) ib.new_in = pulse && (n == 2); else ia.new_in = pulse && (n == 2);
         @(posedge clk);
         #1;
         rc = sel ? ib.req_complete : ia.req_complete;
         if (rc) break;
         @(negedge clk);
      end
      ia.ptrs_req = 1'b0; ib.ptrs_req = 1'b0;
      ia.new_in   = 1'b0; ib.new_in   = 1'b0;

      n_checks++;
      if (n !== lat) begin
         n_fail++;
         $display("FAIL %s latency: got %0d cycles expected %0d", name, n, lat);
      end
      n_checks++;
      g = sel ? 32'(ib.iw_valid) : 32'(ia.iw_valid);
      if (g !== 32'(s.valid)) begin
         n_fail++;
         $display("FAIL %s iw_valid: got %0h expected %0h", name, g, s.valid);
      end
      n_checks++;
      g = sel ? 32'(ib.rd_ptr) : 32'(ia.rd_ptr);
      if (g !== 32'(s.rd)) begin
         n_fail++;
         $display("FAIL %s rd_ptr: got %0h expected %0h", name, g, s.rd);
      end
      n_checks++;
      g = sel ? 32'(ib.coef_base) : 32'(ia.coef_base);
      if (g !== 32'(s.cb)) begin
         n_fail++;
         $display("FAIL %s coef_base: got %0h expected %0h", name, g, s.cb);
      end
      n_checks++;
      g = sel ? 32'(ib.credit_ovf) : 32'(ia.credit_ovf);
      if (g !== 32'(s.ovf)) begin
         n_fail++;
         $display("FAIL %s credit_ovf: got %0h expected %0h", name, g, s.ovf);
      end
`ifdef PTRS_STALL_CNT_EN
      n_checks++;
      g = sel ? 32'(ib.stall_cnt) : 32'(ia.stall_cnt);
      if (g !== 32'(s.stall)) begin
         n_fail++;
         $display("FAIL %s stall_cnt: got %0d expected %0d", name, g, s.stall);
      end
`endif
      if (sel) mb = s; else ma = s;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ia.en = 1'b1; ia.ptrs_req = 1'b0; ia.new_in = 1'b0;
      ib.en = 1'b1; ib.ptrs_req = 1'b0; ib.new_in = 1'b0;
      m_reset(ma);
      m_reset(mb);
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({ia.req_complete, ia.iw_valid, ia.rd_ptr, ia.coef_base, ia.credit_ovf} !== '0) begin
         n_fail++;
         $display("FAIL reset_a: got rc=%b v=%b rd=%h cb=%h ovf=%b expected all 0",
                  ia.req_complete, ia.iw_valid, ia.rd_ptr, ia.coef_base, ia.credit_ovf);
      end
      n_checks++;
      if ({ib.req_complete, ib.iw_valid, ib.rd_ptr, ib.coef_base, ib.credit_ovf} !== '0) begin
         n_fail++;
         $display("FAIL reset_b: got rc=%b v=%b rd=%h cb=%h ovf=%b expected all 0",
                  ib.req_complete, ib.iw_valid, ib.rd_ptr, ib.coef_base, ib.credit_ovf);
      end
`ifdef PTRS_STALL_CNT_EN
      n_checks++;
      if (ia.stall_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_stall: got %0d expected 0", ia.stall_cnt);
      end
`endif
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_no_credit();
      @(negedge clk);
      ia.ptrs_req = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if ({ia.req_complete, ia.iw_valid, ia.rd_ptr, ia.coef_base} !==
             {(k % 3) == 2, 1'b0, AW'(0), ACW'(0)}) begin
            n_fail++;
            $display("FAIL no_credit cycle %0d: got rc=%b v=%b rd=%h cb=%h expected rc=%b v=0 rd=0 cb=0",
                     k, ia.req_complete, ia.iw_valid, ia.rd_ptr, ia.coef_base, (k % 3) == 2);
         end
      end
      ia.ptrs_req = 1'b0;
      ma.stall += 3;
      do_req(1'b0, 1'b0, "no_credit_4");
      do_req(1'b0, 1'b0, "no_credit_5");
   endtask

   task automatic test_basic_sequence();
      pulse_new_in(1'b0);
      do_req(1'b0, 1'b0, "basic_1");
      do_req(1'b0, 1'b0, "basic_2");
      do_req(1'b0, 1'b0, "basic_3_starved");
      pulse_new_in(1'b0);
      do_req(1'b0, 1'b0, "basic_3_retry");
   endtask

   task automatic test_simultaneous();
      pulse_new_in(1'b0);
      do_req(1'b0, 1'b1, "simultaneous");
      n_checks++;
      if (32'(dut_a.credit) !== 32'(ma.credit)) begin
         n_fail++;
         $display("FAIL simultaneous credit: got %0d expected %0d", dut_a.credit, ma.credit);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 2) == 0) pulse_new_in(1'b0);
         else do_req(1'b0, 1'($urandom_range(0, 1)), "random");
         n_checks++;
         if (32'(dut_a.credit) !== 32'(ma.credit)) begin
            n_fail++;
            $display("FAIL random credit step %0d: got %0d expected %0d", i, dut_a.credit, ma.credit);
         end
      end
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 6; i++) begin
         pulse_new_in(1'b1);
         do_req(1'b1, 1'b0, "wrap");
      end
   endtask

   task automatic test_saturation_and_reset();
      repeat (6) pulse_new_in(1'b1);
      n_checks++;
      if ({32'(dut_b.credit), 32'(ib.credit_ovf)} !== {32'(mb.credit), 32'(mb.ovf)}) begin
         n_fail++;
         $display("FAIL saturation: got credit=%0d ovf=%b expected credit=%0d ovf=%b",
                  dut_b.credit, ib.credit_ovf, mb.credit, mb.ovf);
      end
      @(negedge clk);
      ib.ptrs_req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      ib.ptrs_req = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if ({ib.req_complete, ib.iw_valid, ib.rd_ptr, ib.coef_base, ib.credit_ovf, dut_b.credit} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_step: got rc=%b v=%b rd=%h cb=%h ovf=%b credit=%0d expected all 0",
                  ib.req_complete, ib.iw_valid, ib.rd_ptr, ib.coef_base, ib.credit_ovf, dut_b.credit);
      end
      @(negedge clk);
      rst = 1'b0;
      m_reset(ma);
      m_reset(mb);
      do_req(1'b1, 1'b0, "after_reset");
   endtask

   task automatic test_enable_freeze();
      @(negedge clk);
      ia.ptrs_req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      #1;
      ia.ptrs_req = 1'b0;
      ia.en       = 1'b0;
      ia.new_in   = 1'b1;
      m_new_in(ma, AW);
      if (ma.stall < 65535) ma.stall++;
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (ia.req_complete !== 1'b1) begin
            n_fail++;
            $display("FAIL en_freeze cycle %0d: got req_complete=%b expected 1", k, ia.req_complete);
         end
         @(posedge clk);
         #1;
         ia.new_in = 1'b0;
      end
      ia.en = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (ia.req_complete !== 1'b0) begin
         n_fail++;
         $display("FAIL en_release: got req_complete=%b expected 0", ia.req_complete);
      end
      do_req(1'b0, 1'b0, "en_after_freeze");
   endtask

   initial begin
      test_reset();
      test_no_credit();
      test_basic_sequence();
      test_simultaneous();
      test_random();
      test_wrap();
      test_saturation_and_reset();
      test_enable_freeze();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
